// File: rtl/hex_scan_display_pkg.sv
// hex_scan_display_pkg: shared seven-segment constants for the display blocks.
package hex_scan_display_pkg;
  localparam int NUM_DIGITS = 4;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  // Active-low g..a patterns, entry n is the glyph for hex digit n.
  localparam logic [15:0][6:0] SEG_TBL = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
endpackage

// File: rtl/hex_scan_display_hex7seg.sv
// hex7seg: combinational hex nibble to active-low g..a segment decoder.
module hex7seg
  import hex_scan_display_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  assign seg_o = SEG_TBL[nib_i];
endmodule

// File: rtl/hex_scan_display.sv
// hex_scan_display: 4-digit multiplexed common-anode hex display with per-frame
// shadowed value and a stretched carry LED.
module hex_scan_display
  import hex_scan_display_pkg::*;
#(
  parameter int DIV_W     = 17,
  parameter int STRETCH_W = 23,
  parameter int LZB       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           data,
  input  logic                  rc,
  output logic [NUM_DIGITS-1:0] an,
  output logic [7:0]            seg,
  output logic                  rc_led
);
  logic [DIV_W-1:0]      div_q, div_d;
  logic [1:0]            idx_q, idx_d;
  logic [15:0]           shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [7:0]            seg_q, seg_d;
  logic [STRETCH_W-1:0]  st_q, st_d;
  logic                  tick, blank;
  logic [3:0]            nib;
  logic [6:0]            glyph;
  assign tick  = &div_q;
  assign nib   = shadow_q[{idx_q, 2'b00} +: 4];
  // Blank a non-zero digit position when it and every more significant nibble are zero.
  assign blank = (LZB != 0) && (idx_q != 2'd0) && ((shadow_q >> {idx_q, 2'b00}) == 16'd0);
  hex7seg u_hex7seg (.nib_i(nib), .seg_o(glyph));
  always_comb begin
    div_d    = div_q + 1'b1;
    idx_d    = tick ? idx_q + 2'd1 : idx_q;
    shadow_d = (tick && idx_q == 2'd3) ? data : shadow_q;
    an_d     = ~(NUM_DIGITS'(1) << idx_q);
    seg_d    = blank ? SEG_BLANK : {1'b1, glyph};
    st_d     = rc ? '1 : (st_q != '0) ? st_q - 1'b1 : st_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      an_q     <= '1;
      seg_q    <= SEG_BLANK;
      st_q     <= '0;
    end else begin
      div_q    <= div_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      st_q     <= st_d;
    end
  end
  assign an     = an_q;
  assign seg    = seg_q;
  assign rc_led = st_q != '0;
endmodule

// File: tb/tb_hex_scan_display.sv
// tb_hex_scan_display: checks two display instances (blanking off/on) against a cycle-count model.
module tb_hex_scan_display;
  logic        clk, rst, rc;
  logic [15:0] data;
  logic [3:0]  an0, an1;
  logic [7:0]  seg0, seg1;
  logic        led0, led1;
  int checks = 0, passes = 0, fails = 0;
  int n = 0, last_rc = -100, cur_d = -1;
  logic [15:0] shadow_m = '0;
  logic [3:0]  exp_an;
  logic [7:0]  e0, e1;
  logic        led;
  logic [6:0]  pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  hex_scan_display #(.DIV_W(2), .STRETCH_W(3), .LZB(0)) u0 (
    .clk(clk), .rst(rst), .data(data), .rc(rc), .an(an0), .seg(seg0), .rc_led(led0));
  hex_scan_display #(.DIV_W(2), .STRETCH_W(3), .LZB(1)) u1 (
    .clk(clk), .rst(rst), .data(data), .rc(rc), .an(an1), .seg(seg1), .rc_led(led1));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] exp_seg(input int d, input bit lzb);
    logic [15:0] up;
    up = shadow_m >> (4 * d);
    if (lzb && d > 0 && up == 16'd0) return 8'hFF;
    return {1'b1, pat[up[3:0]]};
  endfunction

  task automatic model_reset();
    n = 0; last_rc = -100; shadow_m = '0; cur_d = -1;
    exp_an = 4'hF; e0 = 8'hFF; e1 = 8'hFF; led = 0;
  endtask

  task automatic check_all();
    chk("an_lzb0", {4'h0, an0}, {4'h0, exp_an});
    chk("seg_lzb0", seg0, e0);
    chk("led_lzb0", {7'h0, led0}, {7'h0, led});
    chk("an_lzb1", {4'h0, an1}, {4'h0, exp_an});
    chk("seg_lzb1", seg1, e1);
    chk("led_lzb1", {7'h0, led1}, {7'h0, led});
  endtask

  // Edge n shows the digit that was active during cycle n-1; the shadow is
  // replaced at every 16th edge, and rc at edge m lights the LED for edges m..m+6.
  task automatic cyc();
    @(posedge clk);
    if (rst) model_reset();
    else begin
      n++;
      cur_d  = ((n - 1) / 4) % 4;
      exp_an = ~(4'b0001 << cur_d);
      e0 = exp_seg(cur_d, 0);
      e1 = exp_seg(cur_d, 1);
      if (n % 16 == 0) shadow_m = data;
      if (rc) last_rc = n;
      led = (n - last_rc) < 7;
    end
    #1;
    check_all();
  endtask

  initial begin
    int cnt;
    bit found;
    rst = 1; rc = 0; data = 16'h1234;
    model_reset();
    #2;
    check_all();
    repeat (2) cyc();
    rst = 0;
    repeat (16) cyc();
    data = 16'hA5F0;
    repeat (16) cyc();
    repeat (8) cyc();
    data = 16'h0001;
    repeat (24) cyc();
    data = 16'h0040;
    repeat (32) cyc();
    data = 16'h0000;
    repeat (32) cyc();
    repeat (10) cyc();
    cnt = 0;
    rc = 1; cyc(); cnt += int'(led0);
    rc = 0;
    repeat (12) begin cyc(); cnt += int'(led0); end
    chk("stretch_single", 8'(cnt), 8'd7);
    cnt = 0;
    rc = 1; cyc(); cnt += int'(led0);
    rc = 0;
    repeat (2) begin cyc(); cnt += int'(led0); end
    rc = 1; cyc(); cnt += int'(led0);
    rc = 0;
    repeat (15) begin cyc(); cnt += int'(led0); end
    chk("stretch_retrigger", 8'(cnt), 8'd10);
    for (int v = 0; v < 16; v++) begin
      data = 16'(v) | 16'hBEE0;
      repeat (32) cyc();
    end
    repeat (300) begin
      if ($urandom_range(0, 5) == 0) data = 16'($urandom);
      rc = ($urandom_range(0, 11) == 0);
      cyc();
    end
    data = 16'h9C3D;
    rc = 1;
    found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      cyc();
      if (cur_d == 2) found = 1;
    end
    chk("reach_digit2", {7'h0, found}, 8'd1);
    chk("led_before_rst", {7'h0, led0}, 8'd1);
    rc = 0;
    #2;
    rst = 1;
    #1;
    model_reset();
    check_all();
    repeat (2) cyc();
    rst = 0;
    repeat (40) cyc();
    repeat (200) begin
      if ($urandom_range(0, 3) == 0) data = 16'($urandom) & {4{3'b000, 1'($urandom)}};
      rc = ($urandom_range(0, 15) == 0);
      cyc();
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/hex_scan_display.md
# hex_scan_display

Time-multiplexed 4-digit seven-segment driver sitting directly downstream of the 16-bit up/down counter. It consumes the counter value and its terminal-count (ripple-carry) flag, shows the value as four hex digits on a common-anode display, and stretches the one-cycle carry flag into a visible LED pulse. A per-frame shadow register keeps a digit from changing while it is being shown.

## Interface
Parameters:
- DIV_W, 17: prescaler width; each digit is lit for 2^DIV_W clk cycles.
- STRETCH_W, 23: carry-LED stretch counter width.
- LZB, 0: 1 enables leading-zero blanking.

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  asynchronous, active-high reset.
- data  in  16  counter value, synchronous to clk.
- rc  in  1  counter terminal-count flag, synchronous to clk.
- an  out  4  digit enables, active low; an[0] is the least significant digit.
- seg  out  8  segments, active low; seg[7] is dp, seg[6:0] is g..a.
- rc_led  out  1  stretched carry indicator, active high.

## Operation
- Prescaler `div` (DIV_W bits) increments every clk and wraps.
  - `tick` = (div == all ones).
- Digit index `idx` (2 bits) increments on tick, wrapping 3→0.
- Shadow register `shadow[15:0]` loads `data` on the edge where tick && idx==3, so the new value first shows on digit 0 of the next frame.
- Digit nibble:
  - idx 0 → shadow[3:0]
  - idx 1 → [7:4]
  - idx 2 → [11:8]
  - idx 3 → [15:12]
- Output `an` and `seg` are registered.
  - an <= ~(4'b0001 << idx).
  - seg <= {1'b1, hex7seg(nibble)}. The dp is always off.
- hex7seg patterns (g..a, active low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
- Leading-zero blanking (LZB=1): digit k (k=3..1) shows seg=8'hFF when shadow nibbles k..3 are all zero. `an` is still driven normally. Digit 0 is never blanked.
- Carry stretch counter `st` (STRETCH_W bits):
  - rc=1 at an edge → st <= all ones. This retriggers if already counting.
  - otherwise st <= st-1 while st≠0.
  - rc_led = (st ≠ 0).
- rc and data have no mutual interaction. Simultaneous rc and a shadow load are both honoured.

## Timing
- Reset values:
  - div=0, idx=0, shadow=0, st=0.
  - an=4'b1111, seg=8'hFF, rc_led=0.
- First edge after reset release: an=4'b1110, seg=8'hC0 (digit 0 showing 0).
- Output latency: one cycle from an idx change to the an/seg update. Every digit is lit for exactly 2^DIV_W cycles, and a frame is 4·2^DIV_W cycles.
- `data` is sampled only at the frame-wrap edge. Changes at other times are ignored until the next wrap.
- rc_led rises one edge after rc is sampled high. It stays high for exactly 2^STRETCH_W−1 cycles after the last edge at which rc was high.
- Asynchronous reset mid-frame or mid-stretch immediately forces all reset values. Operation restarts from digit 0.

## Structure
- The segment pattern constants and the digit count (4) belong in a shared package/include, so other display blocks reuse them.
- The natural sub-module is `hex7seg` (4-bit in, 7-bit active-low out, purely combinational), instantiated once.
- The top level holds the prescaler, idx, shadow, output registers and stretch counter.

## Test plan
- Reset and first digit (DIV_W=2): assert rst with data=16'h1234, then release. Required: an/seg=1111/FF during reset; 1110/C0 on the first edge; an 1110 for the first 4 cycles, then 1101, 1011, 0111.
- Frame sampling (DIV_W=2, data=16'hA5F0): after the first wrap the digits read an 1110→seg 0x C0, 1101→8E, 1011→92, 0111→88. Change data mid-frame to 16'h0001; the displayed values must not change until the next frame.
- Leading-zero blanking (LZB=1, data=16'h0040): digit 0 → C0; digit 1 → 99; digits 2 and 3 → FF. data=16'h0000 → digits 3..1 FF, digit 0 C0.
- Carry stretch (STRETCH_W=3): a single-cycle rc pulse must give rc_led high for exactly 7 cycles. A second pulse 3 cycles later must give a total high time of 10 cycles.
- Reset mid-operation: assert rst while in digit 2 with rc_led high. Required: an=1111, seg=FF and rc_led=0 immediately, without waiting for a clock edge; after release the scan restarts at digit 0 and the shadow is 0.
- Full hex sweep: drive all 16 nibble values through digit 0 and check every hex7seg pattern against the table.
